// File: rtl/minisrc_alu_pkg.sv
// Shared types and constants for the nibble-serial adder:
// FSM state encoding and the nibble width.
package minisrc_alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice. c3 is the carry into bit 3,
// g/p are the group generate/propagate of the whole nibble.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       c3,
  output logic       g,
  output logic       p
);

  logic [3:0] w_gi;
  logic [3:0] w_pi;
  logic       w_c1;
  logic       w_c2;

  assign w_gi = x & y;
  assign w_pi = x ^ y;

  assign w_c1 = w_gi[0] | (w_pi[0] & c_in);
  assign w_c2 = w_gi[1] | (w_pi[1] & w_gi[0]) | (w_pi[1] & w_pi[0] & c_in);
  assign c3   = w_gi[2] | (w_pi[2] & w_gi[1]) | (w_pi[2] & w_pi[1] & w_gi[0])
              | (w_pi[2] & w_pi[1] & w_pi[0] & c_in);

  assign g = w_gi[3] | (w_pi[3] & w_gi[2]) | (w_pi[3] & w_pi[2] & w_gi[1])
           | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
  assign p = &w_pi;

  assign c_out = g | (p & c_in);
  assign s     = w_pi ^ {c3, w_c2, w_c1, c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract using one time-shared 4-bit CLA slice.
// Define NIBBLE_ADD_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one nibble per cycle through the slice, LSB nibble first
// DONE  | result held until out_ready
module nibble_serial_adder
  import minisrc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NIB - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_step;

  logic             w_accept;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [3:0]       w_s;
  logic             w_cout;
  logic             w_c3;
  logic             w_grp_g_unused;
  logic             w_grp_p_unused;

  cla4_slice u_slice (
    .x     (r_opa[NIBBLE_W-1:0]),
    .y     (r_opb[NIBBLE_W-1:0]),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_cout),
    .c3    (w_c3),
    .g     (w_grp_g_unused),
    .p     (w_grp_p_unused)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end
      end
      RUN: begin
        if (r_step == LAST_STEP) begin
          w_state_nxt = DONE;
          w_last      = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are forced low while clr_n is asserted.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    if (clr_n) begin
      w_in_ready  = (r_state == IDLE);
      w_out_valid = (r_state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= sub;
        r_step  <= '0;
      end else if (r_state == RUN) begin
        r_sum   <= {w_s, r_sum[WIDTH-1:NIBBLE_W]};
        r_carry <= w_cout;
        r_opa   <= r_opa >> NIBBLE_W;
        r_opb   <= r_opb >> NIBBLE_W;
        r_step  <= r_step + CW'(1);
      end
    end
  end

`ifdef NIBBLE_ADD_OVF_EN
  logic r_ovf;

  // Overflow is carry into the sign bit XOR carry out of it, taken on the last step.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_c3 ^ w_cout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_carry;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have derived localparam NIB = WIDTH/4: the number of nibble steps per operation.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port clr_n, input, 1 bit: reset; synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: a request is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port a, input, WIDTH bits: first operand.
REQ-008 SHALL have port b, input, WIDTH bits: second operand.
REQ-009 SHALL have port sub, input, 1 bit: 0 computes a+b; 1 computes a-b as a + ~b + 1.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is held on the outputs.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: the result.
REQ-013 SHALL have port c_out, output, 1 bit: carry out of the MSB nibble.
REQ-014 SHALL have port ovf, output, 1 bit: signed overflow; present only under the macro in REQ-031.

Function
REQ-015 SHALL contain exactly one 4-bit carry-lookahead slice, time-shared across all nibbles, LSB nibble first.
REQ-016 SHALL implement three FSM states:
 - IDLE: in_ready=1, out_valid=0.
 - RUN: in_ready=0, out_valid=0.
 - DONE: in_ready=0, out_valid=1.
REQ-017 SHALL take the transition IDLE->RUN when in_valid is high in IDLE, and on that edge SHALL:
 - latch a into an operand shift register;
 - latch b, or ~b when sub=1, into a second operand shift register;
 - set the carry register to sub;
 - clear the step counter to 0.
REQ-018 SHALL, on each RUN cycle:
 - feed the low nibbles of both shift registers and the carry register to the slice;
 - shift the slice sum into the result register from the MSB end;
 - load the slice carry-out into the carry register;
 - shift both operand registers right by 4;
 - increment the step counter.
REQ-019 SHALL take the transition RUN->DONE on the edge where the step counter equals NIB-1; c_out then holds the final carry.
REQ-020 SHALL give a latency of exactly NIB+1 cycles from the accepting edge to the first cycle with out_valid=1 (9 cycles for WIDTH=32).
REQ-021 SHALL hold sum, c_out and ovf stable while in DONE and out_ready is low.
REQ-022 SHALL take the transition DONE->IDLE on the edge where out_ready is high; a new request is accepted no earlier than the following cycle, so there is no back-to-back overlap.
REQ-023 SHALL ignore in_valid, a, b and sub outside IDLE; changes to them in RUN or DONE SHALL NOT affect the result.
REQ-024 SHALL compute all arithmetic modulo 2^WIDTH; c_out SHALL equal bit WIDTH of {0,a} + {0,b'} + sub, where b' is the latched second operand (b, or ~b when sub=1); for subtraction c_out=1 means no borrow.
REQ-025 SHALL keep the unused state encoding unreachable; if entered, the FSM SHALL return to IDLE on the next edge.

Reset
REQ-026 SHALL, on any edge with clr_n=0, enter IDLE and zero sum, c_out, ovf, the carry register, the step counter and both shift registers.
REQ-027 SHALL, during reset, drive in_ready=0 and out_valid=0, with in_ready rising in the first cycle after clr_n returns high.
REQ-028 SHALL abort any operation in RUN or DONE that is hit by reset, with no result emitted.

Configuration
REQ-029 SHALL, with macro NIBBLE_ADD_OVF_EN defined, provide the ovf port.
REQ-030 SHALL compute ovf in the RUN->DONE transition as the carry-in of the MSB bit XOR the final carry-out, using the slice's internal bit-3 carry.
REQ-031 SHALL, without NIBBLE_ADD_OVF_EN defined, omit the ovf port and its logic entirely; all other behaviour SHALL be identical.

Structure
REQ-032 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the constant NIBBLE_W=4 in the shared package minisrc_alu_pkg.
REQ-033 SHALL contain one sub-module, cla4_slice: combinational 4-bit CLA with inputs x, y, c_in and outputs s, c_out, c3, g, p, where c3 is the carry into bit 3.

Verification
REQ-034 SHALL cover: a=0x0000_000F, b=0x0000_0001, sub=0 -> sum=0x0000_0010, c_out=0, out_valid on the 9th cycle after acceptance.
REQ-035 SHALL cover: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x0000_0000, c_out=1, ovf=0.
REQ-036 SHALL cover: a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x8000_0000, ovf=1; and a=0x0000_0005, b=0x0000_0007, sub=1 -> sum=0xFFFF_FFFE, c_out=0.
REQ-037 SHALL cover: out_ready held low for 5 cycles in DONE with in_valid=1 and a changing -> sum unchanged, in_ready=0; release out_ready -> IDLE, then the next request is accepted.
REQ-038 SHALL cover: clr_n=0 at RUN step 3 -> next cycle IDLE with all outputs 0; a subsequent request completes correctly.
REQ-039 SHALL cover: 10,000 random a/b/sub with random out_ready stalls, scored against a behavioural model, at WIDTH=32 and WIDTH=8.
